inference_sequencer: RTL

//  Central scheduler for the 784->512->512->10 inference chain. Starts layer 1 on a received image,

---
 rtl/inference_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/inference_sequencer.sv
// Scheduler for the three-layer inference chain: starts layers in order, decodes the result,
// buffers one pending image, counts dropped images and guards each stage with a watchdog.
module inference_sequencer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int OVR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             img_ready,
  output logic             l1_start,
  input  logic             l1_done,
  output logic             l2_start,
  input  logic             l2_done,
  output logic             l3_start,
  input  logic             l3_done,
  input  logic [9:0]       a3,
  input  logic             clear_err,
  output logic             disp_en,
  output logic [3:0]       digit_out,
  output logic             ambiguous,
  output logic             busy,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic             timeout_err,
  output logic [1:0]       err_stage
);

  // state  | meaning
  // IDLE   | waiting for an image
  // RUN_L1 | layer 1 computing
  // RUN_L2 | layer 2 computing
  // RUN_L3 | layer 3 computing
  // DONE   | one cycle: result decoded, display pulsed
  // ERR    | a stage timed out; waits for clear_err
  typedef enum logic [2:0] {IDLE, RUN_L1, RUN_L2, RUN_L3, DONE, ERR} state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic WD_ON = (TIMEOUT_CYCLES > 0);

  state_t          state, next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            pending, pending_next;
  logic            ovr_inc;
  logic [3:0]      dec_digit;
  logic            dec_amb;
  logic [1:0]      stage_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    pending_next = pending;
    ovr_inc      = 1'b0;
    wd_expire    = WD_ON && (wd_cnt == WD_LAST);
    stage_id     = 2'd0;
    case (state)
      IDLE: begin
        if (img_ready || pending) next_state = RUN_L1;
        // entry consumes one image; a simultaneous second one stays buffered
        pending_next = pending && img_ready;
      end
      RUN_L1: begin
        stage_id = 2'd1;
        if (l1_done)        next_state = RUN_L2;
        else if (wd_expire) next_state = ERR;
      end
      RUN_L2: begin
        stage_id = 2'd2;
        if (l2_done)        next_state = RUN_L3;
        else if (wd_expire) next_state = ERR;
      end
      RUN_L3: begin
        stage_id = 2'd3;
        if (l3_done)        next_state = DONE;
        else if (wd_expire) next_state = ERR;
      end
      DONE: begin
        // an image arriving now starts directly, so it is never lost on the way to IDLE
        next_state   = (pending || img_ready) ? RUN_L1 : IDLE;
        ovr_inc      = pending && img_ready;
        pending_next = 1'b0;
      end
      ERR: begin
        if (clear_err) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (state inside {RUN_L1, RUN_L2, RUN_L3}) begin
      if (next_state == ERR) begin
        pending_next = 1'b0;
        ovr_inc      = img_ready;
      end else if (img_ready) begin
        ovr_inc      = pending;
        pending_next = 1'b1;
      end
    end else if (state == ERR) begin
      pending_next = 1'b0;
      ovr_inc      = img_ready;
    end
  end

  always_comb begin
    dec_digit = 4'hF;
    dec_amb   = 1'b1;
    if ($countones(a3) == 1) begin
      dec_amb = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (a3[i]) dec_digit = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      wd_cnt      <= '0;
      overrun_cnt <= '0;
      l1_start    <= 1'b0;
      l2_start    <= 1'b0;
      l3_start    <= 1'b0;
      disp_en     <= 1'b0;
      digit_out   <= 4'd0;
      ambiguous   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= 2'd0;
    end else begin
      pending <= pending_next;
      if (next_state != state) wd_cnt <= '0;
      else                     wd_cnt <= wd_cnt + WD_W'(1);
      if (ovr_inc && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + OVR_W'(1);
      l1_start <= (next_state == RUN_L1) && (state != RUN_L1);
      l2_start <= (next_state == RUN_L2) && (state != RUN_L2);
      l3_start <= (next_state == RUN_L3) && (state != RUN_L3);
      disp_en  <= (next_state == DONE);
      busy     <= next_state inside {RUN_L1, RUN_L2, RUN_L3, DONE};
      if (next_state == DONE) begin
        digit_out <= dec_digit;
        ambiguous <= dec_amb;
      end
      if ((next_state == ERR) && (state != ERR)) begin
        timeout_err <= 1'b1;
        err_stage   <= stage_id;
      end else if ((state == ERR) && clear_err) begin
        timeout_err <= 1'b0;
        err_stage   <= 2'd0;
      end
    end
  end

endmodule
